// File: rtl/pio_loader_if.sv
// pio_loader_if: ROM, upstream and PIO-side signals of the loader
interface pio_loader_if;
    logic        reload;
    logic [4:0]  prog_addr;
    logic [15:0] prog_data;
    logic [4:0]  conf_addr;
    logic [35:0] conf_data;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic        full;
    logic [3:0]  action;
    logic [31:0] din;
    logic [4:0]  index;
    logic [1:0]  mindex;
    logic        done;
    logic [7:0]  stall_cnt;
    modport master (
        input  reload, prog_data, conf_data, tx_valid, tx_data, full,
        output prog_addr, conf_addr, tx_ready, action, din, index, mindex, done, stall_cnt
    );
    modport slave (
        output reload, prog_data, conf_data, tx_valid, tx_data, full,
        input  prog_addr, conf_addr, tx_ready, action, din, index, mindex, done, stall_cnt
    );
endinterface

// File: rtl/pio_loader.sv
// pio_loader: loads program and config ROMs into a PIO machine, then forwards upstream words into its TX FIFO
module pio_loader #(
    parameter int PROG_LEN = 32,
    parameter int CONF_LEN = 5,
    parameter int MACHINE  = 0
) (
    input logic        clk,
    input logic        reset,
    pio_loader_if.master bus
);
    typedef enum logic [1:0] {LOAD_PROG, LOAD_CONF, RUN} state_t;
    state_t     state;
    logic [5:0] cnt;
    logic       pv;
    logic       cv;
    logic [4:0] pk;
    assign bus.prog_addr = state == LOAD_PROG ? cnt[4:0] : 5'd0;
    assign bus.conf_addr = state == LOAD_CONF ? cnt[4:0] : 5'd0;
    assign bus.tx_ready  = state == RUN && !bus.full && bus.action != 4'd4;
    assign bus.mindex    = 2'(MACHINE);
    // LOAD_CONF runs two extra cycles past the last entry so RUN starts exactly when the ROM pipeline has drained
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= LOAD_PROG;
            cnt           <= '0;
            pv            <= 1'b0;
            cv            <= 1'b0;
            pk            <= '0;
            bus.action    <= '0;
            bus.din       <= '0;
            bus.index     <= '0;
            bus.done      <= 1'b0;
            bus.stall_cnt <= '0;
        end else begin
            pv         <= state == LOAD_PROG;
            pk         <= cnt[4:0];
            cv         <= state == LOAD_CONF && cnt < 6'(CONF_LEN);
            bus.action <= 4'd0;
            if (pv) begin
                bus.action <= 4'd1;
                bus.index  <= pk;
                bus.din    <= {16'h0, bus.prog_data};
            end else if (cv) begin
                bus.action <= bus.conf_data[35:32];
                bus.index  <= 5'd0;
                bus.din    <= bus.conf_data[31:0];
            end else if (bus.tx_valid && bus.tx_ready) begin
                bus.action <= 4'd4;
                bus.index  <= 5'd0;
                bus.din    <= bus.tx_data;
            end
            case (state)
                LOAD_PROG: begin
                    cnt   <= cnt == 6'(PROG_LEN - 1) ? 6'd0 : cnt + 6'd1;
                    state <= cnt == 6'(PROG_LEN - 1) ? LOAD_CONF : LOAD_PROG;
                end
                LOAD_CONF: begin
                    cnt      <= cnt == 6'(CONF_LEN + 1) ? 6'd0 : cnt + 6'd1;
                    state    <= cnt == 6'(CONF_LEN + 1) ? RUN : LOAD_CONF;
                    bus.done <= cnt == 6'(CONF_LEN + 1);
                end
                RUN: begin
                    if (bus.tx_valid && bus.full && bus.stall_cnt != 8'hff)
                        bus.stall_cnt <= bus.stall_cnt + 8'd1;
                    if (bus.reload) begin
                        state    <= LOAD_PROG;
                        cnt      <= 6'd0;
                        bus.done <= 1'b0;
                    end
                end
                default: state <= LOAD_PROG;
            endcase
        end
    end
endmodule

// File: tb/tb_pio_loader.sv
// tb_pio_loader: directed checks of loading, pushing, stalls, reload and reset
module tb_pio_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    pio_loader_if a_if ();
    pio_loader_if b_if ();
    pio_loader #(.PROG_LEN(32), .CONF_LEN(5), .MACHINE(2)) dut_a (.clk(clk), .reset(reset), .bus(a_if.master));
    pio_loader #(.PROG_LEN(32), .CONF_LEN(0), .MACHINE(1)) dut_b (.clk(clk), .reset(reset), .bus(b_if.master));
    always #5 clk = ~clk;
    function automatic logic [15:0] prog_word(input logic [4:0] a);
        return 16'hA000 + 16'(a);
    endfunction
    function automatic logic [35:0] conf_word(input logic [4:0] a);
        return a < 5'd5 ? {(a == 5'd2 ? 4'd0 : 4'(a) + 4'd2), 32'hC000_0000 + 32'(a)} : 36'h0;
    endfunction
    // synchronous ROM models with one-cycle read latency
    always @(posedge clk) begin
        a_if.prog_data <= prog_word(a_if.prog_addr);
        a_if.conf_data <= conf_word(a_if.conf_addr);
        b_if.prog_data <= prog_word(b_if.prog_addr);
        b_if.conf_data <= conf_word(b_if.conf_addr);
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        a_if.reload = 0; a_if.tx_valid = 0; a_if.tx_data = 0; a_if.full = 0;
        b_if.reload = 0; b_if.tx_valid = 0; b_if.tx_data = 0; b_if.full = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", {a_if.action, a_if.din, a_if.index, a_if.done, a_if.stall_cnt}, 64'h0);
        chk("rst_addr", {a_if.prog_addr, a_if.conf_addr}, 10'h0);
        chk("mindex", {a_if.mindex, b_if.mindex}, 4'b1001);
        @(negedge clk) reset = 0;
        step();
        chk("pipe_idle", a_if.action, 4'd0);
        step();
        for (int k = 0; k < 32; k++) begin
            chk("prog", {a_if.action, a_if.index, a_if.din}, {4'd1, 5'(k), 16'h0, prog_word(5'(k))});
            if (k == 5) begin
                a_if.full = 1;
                #1;
                chk("load_rdy_full", a_if.tx_ready, 1'b0);
                a_if.full = 0;
                a_if.reload = 1;
                #1;
                chk("load_rdy", a_if.tx_ready, 1'b0);
            end
            if (k == 6) a_if.reload = 0;
            if (k == 31) chk("b_last", {b_if.action, b_if.index, b_if.done}, {4'd1, 5'd31, 1'b0});
            step();
        end
        for (int j = 0; j < 5; j++) begin
            chk("conf", {a_if.action, a_if.index, a_if.din}, {conf_word(5'(j))[35:32], 5'd0, conf_word(5'(j))[31:0]});
            chk("conf_done", a_if.done, 1'b0);
            if (j == 0) chk("b_done", {b_if.action, b_if.done}, {4'd0, 1'b1});
            step();
        end
        chk("load_end", {a_if.action, a_if.done, a_if.stall_cnt}, {4'd0, 1'b1, 8'd0});
        for (int i = 0; i < 3; i++) begin
            a_if.tx_valid = 1;
            a_if.tx_data = 32'h30 + 32'(i);
            #1;
            chk("push_rdy", a_if.tx_ready, 1'b1);
            step();
            chk("push", {a_if.action, a_if.index, a_if.din}, {4'd4, 5'd0, 32'h30 + 32'(i)});
            if (i < 2) a_if.tx_data = 32'h31 + 32'(i);
            else a_if.tx_valid = 0;
            #1;
            chk("push_busy", a_if.tx_ready, 1'b0);
            step();
            chk("push_gap", a_if.action, 4'd0);
        end
        a_if.full = 1;
        a_if.tx_valid = 1;
        a_if.tx_data = 32'h55;
        #1;
        chk("stall_rdy", a_if.tx_ready, 1'b0);
        repeat (300) step();
        chk("stall", {a_if.action, a_if.tx_ready, a_if.stall_cnt}, {4'd0, 1'b0, 8'd255});
        a_if.full = 0;
        #1;
        step();
        chk("stall_push", {a_if.action, a_if.din}, {4'd4, 32'h55});
        a_if.tx_valid = 0;
        step();
        chk("stall_after", {a_if.action, a_if.stall_cnt}, {4'd0, 8'd255});
        a_if.reload = 1;
        step();
        a_if.reload = 0;
        chk("reload", {a_if.done, a_if.prog_addr, a_if.action}, {1'b0, 5'd0, 4'd0});
        step();
        step();
        chk("reload_w0", {a_if.action, a_if.index, a_if.din}, {4'd1, 5'd0, 16'h0, prog_word(5'd0)});
        chk("reload_stall", a_if.stall_cnt, 8'd255);
        repeat (10) step();
        chk("mid_w10", {a_if.action, a_if.index}, {4'd1, 5'd10});
        reset = 1;
        #1;
        chk("async_rst", {a_if.action, a_if.din, a_if.index, a_if.done, a_if.stall_cnt, a_if.prog_addr}, 64'h0);
        @(negedge clk) reset = 0;
        step();
        step();
        chk("rst_w0", {a_if.action, a_if.index, a_if.din}, {4'd1, 5'd0, 16'h0, prog_word(5'd0)});
        for (int t = 0; t < 100 && !a_if.done; t++) step();
        chk("wait_done", a_if.done, 1'b1);
        a_if.tx_valid = 1;
        a_if.tx_data = 32'h77;
        a_if.reload = 1;
        step();
        a_if.tx_valid = 0;
        a_if.reload = 0;
        chk("rl_push", {a_if.action, a_if.din, a_if.done, a_if.prog_addr}, {4'd4, 32'h77, 1'b0, 5'd0});
        step();
        chk("rl_next", {a_if.action, a_if.prog_addr}, {4'd0, 5'd1});
        step();
        chk("rl_w0", {a_if.action, a_if.index}, {4'd1, 5'd0});
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pio_loader.md
PIO_LOADER -- requirements
Module: pio_loader

Interface
REQ-001 SHALL have parameter PROG_LEN, default 32, number of program words written (1..32).
REQ-002 SHALL have parameter CONF_LEN, default 5, number of configuration entries written (0..31).
REQ-003 SHALL have parameter MACHINE, default 0, 2-bit state machine index driven on mindex.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port reload  input  1  synchronous request to restart loading; honoured only in RUN.
REQ-007 SHALL have port prog_addr  output  5  program ROM address; ROM returns data one cycle later.
REQ-008 SHALL have port prog_data  input  16  program ROM read data.
REQ-009 SHALL have port conf_addr  output  5  config ROM address; one-cycle read latency.
REQ-010 SHALL have port conf_data  input  36  config entry: [35:32] action, [31:0] data.
REQ-011 SHALL have port tx_valid  input  1  upstream word available.
REQ-012 SHALL have port tx_data  input  32  upstream word to push into the machine TX FIFO.
REQ-013 SHALL have port tx_ready  output  1  upstream word accepted this cycle when tx_valid also high.
REQ-014 SHALL have port full  input  1  TX FIFO full flag of machine MACHINE from the PIO.
REQ-015 SHALL have port action  output  4  registered PIO action code (0 none, 1 instruction write, 4 push).
REQ-016 SHALL have port din  output  32  registered PIO data.
REQ-017 SHALL have port index  output  5  registered PIO instruction index.
REQ-018 SHALL have port mindex  output  2  constant MACHINE.
REQ-019 SHALL have port done  output  1  high while in RUN.
REQ-020 SHALL have port stall_cnt  output  8  saturating count of cycles blocked by full.

Function
REQ-021 SHALL implement states LOAD_PROG, LOAD_CONF, RUN; LOAD_PROG entered from reset or reload.
REQ-022 LOAD_PROG SHALL step prog_addr 0..PROG_LEN-1, one address per cycle, then enter LOAD_CONF.
REQ-023 Program word k SHALL appear as action=1, index=k, din={16'h0,program[k]} exactly two cycles after prog_addr=k, one cycle each, no gaps.
REQ-024 LOAD_CONF SHALL step conf_addr 0..CONF_LEN-1; entry j SHALL appear as action=conf_data[35:32], din=conf_data[31:0], index=0 in the cycle immediately after the last program write plus j.
REQ-025 Config entry with action field 0 SHALL be passed through unchanged (no-op cycle, still counted).
REQ-026 With CONF_LEN=0 SHALL go directly from LOAD_PROG to RUN.
REQ-027 action SHALL be 0 in the cycle following the last configuration write and in every RUN cycle without a push.
REQ-028 done SHALL rise in the same cycle action first returns to 0 after loading.
REQ-029 tx_ready SHALL equal (state==RUN) && !full && (action!=4).
REQ-030 On tx_valid && tx_ready, next cycle SHALL drive action=4, din=tx_data, index=0; following cycle action=0 (max one push per two cycles).
REQ-031 stall_cnt SHALL increment in each RUN cycle with tx_valid && full, holding at 255.
REQ-032 reload in RUN with a push accepted in the same cycle SHALL complete that push, then begin LOAD_PROG at address 0 the cycle after; stall_cnt preserved.
REQ-033 reload outside RUN SHALL be ignored.
REQ-034 tx_ready SHALL be 0 throughout LOAD_PROG and LOAD_CONF regardless of full.

Reset
REQ-035 reset SHALL asynchronously force LOAD_PROG, prog_addr=0, conf_addr=0, action=0, din=0, index=0, done=0, stall_cnt=0.
REQ-036 reset asserted mid-load or mid-push SHALL abandon the operation; loading restarts at program address 0 after release.

Verification
REQ-037 Reset release, PROG_LEN=32, CONF_LEN=5 -> 32 consecutive action=1 writes index 0..31 starting cycle 2, then 5 config writes, action=0 and done=1 at cycle 39.
REQ-038 RUN, full=0, tx_valid held with 0x30,0x31,0x32 -> action=4 pulses with din 0x30,0x31,0x32 on alternate cycles, action=0 between.
REQ-039 RUN, full=1 for 300 cycles with tx_valid=1 -> tx_ready=0, no push, stall_cnt=255; full drops -> push of held word next cycle.
REQ-040 reload pulse in RUN -> done=0 next cycle, program rewritten from index 0, stall_cnt unchanged.
REQ-041 reset asserted at program index 10 -> outputs zero immediately; after release writes restart at index 0.
REQ-042 CONF_LEN=0 -> done=1 in cycle after index 31 write; config entry with action 0 -> action=0 cycle counted, no shift of later entries.
